// File: rtl/hwag_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hwag_pkg
// Purpose  : Shared types and constants for the hardware angle generator
//            crank/cam synchronisation logic.
// Revision : 1.0  initial release
// ============================================================================
package hwag_pkg;

    // Synchronisation state as seen by software and the angle generator
    typedef enum logic [1:0] {
        SYNC_STOP   = 2'd0,
        SYNC_SEEK   = 2'd1,
        SYNC_VERIFY = 2'd2,
        SYNC_LOCK   = 2'd3
    } sync_state_t;

    // Reason for the most recent loss of synchronisation
    typedef enum logic [1:0] {
        ERR_NONE        = 2'd0,
        ERR_EARLY_GAP   = 2'd1,
        ERR_MISSING_GAP = 2'd2,
        ERR_STALL       = 2'd3
    } err_code_t;

    // A gap tooth is at least (1 << GAP_RATIO_SHIFT) times the previous period
    localparam int GAP_RATIO_SHIFT = 1;
    // Real teeth on a 60-2 wheel
    localparam int TOOTH_NUM_DEF   = 58;

endpackage : hwag_pkg
`default_nettype wire

// File: rtl/hwag_gap_det.sv
`default_nettype none
// ============================================================================
// Module   : hwag_gap_det
// Purpose  : Missing-tooth gap detector. Remembers the previous tooth period
//            and flags the current one as a gap when it is at least twice
//            as long. The flag is suppressed until a period has been stored.
// Revision : 1.0  initial release
// ============================================================================
module hwag_gap_det
    import hwag_pkg::*;
#(
    parameter int PERIOD_W = 24
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_clr,
    input  logic                i_load,
    input  logic [PERIOD_W-1:0] i_period,
    output logic                o_gap
);

    logic [PERIOD_W-1:0] r_prev_period;
    logic                r_prev_valid;
    logic [PERIOD_W:0]   w_thresh;

    // Previous-period storage; a clear wins so the reference is rebuilt after STOP
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_prev_period <= '0;
            r_prev_valid  <= 1'b0;
        end else begin
            if (i_load) begin
                r_prev_period <= i_period;
            end
            if (i_clr) begin
                r_prev_valid <= 1'b0;
            end else if (i_load) begin
                r_prev_valid <= 1'b1;
            end
        end
    end

    // Ratio test at one extra bit so doubling a large period cannot wrap
    always_comb begin
        w_thresh = {1'b0, r_prev_period} << GAP_RATIO_SHIFT;
        o_gap    = r_prev_valid && ({1'b0, i_period} >= w_thresh);
    end

endmodule : hwag_gap_det
`default_nettype wire

// File: rtl/hwag_sync_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hwag_sync_ctrl
// Purpose  : Crank/cam synchronisation for a 60-2 wheel. Finds the gap,
//            verifies one full revolution, then tracks tooth index and the
//            720 degree cam phase. Reports loss of sync and engine stall.
// Revision : 1.0  initial release
// ============================================================================
module hwag_sync_ctrl
    import hwag_pkg::*;
#(
    parameter int TOOTH_NUM = TOOTH_NUM_DEF,
    parameter int PERIOD_W  = 24,
    parameter int CAM_TOOTH = 30
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         tooth_stb,
    input  logic [PERIOD_W-1:0]          tooth_period,
    input  logic                         cam_lvl,
    input  logic [PERIOD_W-1:0]          stall_limit,
    output logic [1:0]                   sync_state,
    output logic                         angle_en,
    output logic [$clog2(TOOTH_NUM)-1:0] tooth_idx,
    output logic                         phase,
    output logic                         phase_valid,
    output logic                         gap_stb,
    output logic                         err_stb,
    output logic [1:0]                   err_code
);

    localparam int IDX_W = $clog2(TOOTH_NUM);

    localparam logic [1:0]       c_st_stop   = SYNC_STOP;
    localparam logic [1:0]       c_st_seek   = SYNC_SEEK;
    localparam logic [1:0]       c_st_verify = SYNC_VERIFY;
    localparam logic [1:0]       c_st_lock   = SYNC_LOCK;
    localparam logic [IDX_W-1:0] c_last      = IDX_W'(TOOTH_NUM - 1);
    localparam logic [IDX_W-1:0] c_cam       = IDX_W'(CAM_TOOTH);

    logic [1:0]          r_state;
    logic [IDX_W-1:0]    r_idx;
    logic [IDX_W-1:0]    r_cnt;
    logic                r_phase;
    logic                r_phase_valid;
    logic                r_cam_smp;
    logic                r_cam_seen;
    logic                r_gap_stb;
    logic                r_err_stb;
    err_code_t           r_err_code;
    logic [PERIOD_W-1:0] r_stall;
    logic [PERIOD_W-1:0] w_stall_inc;
    logic                w_stall_hit;
    logic                w_gap;
    logic                w_gd_clr;

    // The period reference is dropped while stopped unless this strobe restarts sync
    assign w_gd_clr = !en || ((r_state == c_st_stop) && !tooth_stb);

    hwag_gap_det #(
        .PERIOD_W (PERIOD_W)
    ) u_gap_det (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (w_gd_clr),
        .i_load   (tooth_stb),
        .i_period (tooth_period),
        .o_gap    (w_gap)
    );

    // Stall threshold is tested on the value the counter is about to take,
    // so the stop lands exactly stall_limit cycles after the last strobe
    always_comb begin
        w_stall_inc = (r_stall == '1) ? r_stall : r_stall + 1'b1;
        w_stall_hit = !tooth_stb && (r_state != c_st_stop) && (w_stall_inc >= stall_limit);
    end

    // Idle-time counter, saturating, cleared by every tooth
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall <= '0;
        end else if (tooth_stb) begin
            r_stall <= '0;
        end else begin
            r_stall <= w_stall_inc;
        end
    end

    // Sync state machine with tooth/verify counters, cam phase and error reporting
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= c_st_stop;
            r_idx         <= '0;
            r_cnt         <= '0;
            r_phase       <= 1'b0;
            r_phase_valid <= 1'b0;
            r_cam_smp     <= 1'b0;
            r_cam_seen    <= 1'b0;
            r_gap_stb     <= 1'b0;
            r_err_stb     <= 1'b0;
            r_err_code    <= ERR_NONE;
        end else begin
            r_gap_stb <= 1'b0;
            r_err_stb <= 1'b0;
            if (!en) begin
                r_state       <= c_st_stop;
                r_phase_valid <= 1'b0;
                r_cam_seen    <= 1'b0;
            end else if (w_stall_hit) begin
                r_state       <= c_st_stop;
                r_err_stb     <= 1'b1;
                r_err_code    <= ERR_STALL;
                r_phase_valid <= 1'b0;
                r_cam_seen    <= 1'b0;
            end else if (tooth_stb) begin
                case (r_state)
                    c_st_stop: begin
                        r_state <= c_st_seek;
                    end
                    c_st_seek: begin
                        if (w_gap) begin
                            r_state <= c_st_verify;
                            r_cnt   <= '0;
                        end
                    end
                    c_st_verify: begin
                        // Errors here only update the code; no strobe before lock
                        if (w_gap) begin
                            if (r_cnt == c_last) begin
                                r_state <= c_st_lock;
                                r_idx   <= '0;
                            end else begin
                                r_state    <= c_st_seek;
                                r_err_code <= ERR_EARLY_GAP;
                            end
                        end else if (r_cnt == c_last) begin
                            r_state    <= c_st_seek;
                            r_err_code <= ERR_MISSING_GAP;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    default: begin
                        if (w_gap && (r_idx == c_last)) begin
                            r_idx     <= '0;
                            r_gap_stb <= 1'b1;
                            // Trust the cam when it was seen, otherwise free-run the phase
                            if (r_cam_seen) begin
                                r_phase       <= r_cam_smp;
                                r_phase_valid <= 1'b1;
                            end else begin
                                r_phase <= ~r_phase;
                            end
                            r_cam_seen <= 1'b0;
                        end else if (w_gap || (r_idx == c_last)) begin
                            r_state       <= c_st_seek;
                            r_err_stb     <= 1'b1;
                            r_err_code    <= w_gap ? ERR_EARLY_GAP : ERR_MISSING_GAP;
                            r_phase_valid <= 1'b0;
                            r_cam_seen    <= 1'b0;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                            // Sample the cam on the strobe that lands the index on the cam tooth
                            if ((r_idx + 1'b1) == c_cam) begin
                                r_cam_smp  <= cam_lvl;
                                r_cam_seen <= 1'b1;
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign sync_state  = r_state;
    assign angle_en    = (r_state == c_st_lock);
    assign tooth_idx   = r_idx;
    assign phase       = r_phase;
    assign phase_valid = r_phase_valid;
    assign gap_stb     = r_gap_stb;
    assign err_stb     = r_err_stb;
    assign err_code    = r_err_code;

endmodule : hwag_sync_ctrl
`default_nettype wire

// File: tb/tb_hwag_sync_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hwag_sync_ctrl
// Purpose  : Self-checking bench for hwag_sync_ctrl. A cycle model of the
//            sync behaviour queues the expected outputs for every driven
//            cycle; they are compared one edge later.
// Revision : 1.0  initial release
// ============================================================================
module tb_hwag_sync_ctrl;
    import hwag_pkg::*;

    localparam int PW = 24;
    localparam int TN = 58;
    localparam int CT = 30;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en = 1'b0;
    logic          tooth_stb = 1'b0;
    logic [PW-1:0] tooth_period = '0;
    logic          cam_lvl = 1'b0;
    logic [PW-1:0] stall_limit = PW'(1000);
    logic [1:0]    sync_state;
    logic          angle_en;
    logic [5:0]    tooth_idx;
    logic          phase;
    logic          phase_valid;
    logic          gap_stb;
    logic          err_stb;
    logic [1:0]    err_code;

    hwag_sync_ctrl #(
        .TOOTH_NUM (TN),
        .PERIOD_W  (PW),
        .CAM_TOOTH (CT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .tooth_stb    (tooth_stb),
        .tooth_period (tooth_period),
        .cam_lvl      (cam_lvl),
        .stall_limit  (stall_limit),
        .sync_state   (sync_state),
        .angle_en     (angle_en),
        .tooth_idx    (tooth_idx),
        .phase        (phase),
        .phase_valid  (phase_valid),
        .gap_stb      (gap_stb),
        .err_stb      (err_stb),
        .err_code     (err_code)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] st;
        logic [5:0] idx;
        logic       ph;
        logic       pv;
        logic       gs;
        logic       es;
        logic [1:0] ec;
    } exp_t;

    exp_t sb_q[$];
    int   n_total = 0;
    int   n_bad   = 0;
    int   es_seen = 0;
    bit   cam_rev = 1'b0;

    // Reference model state
    logic [1:0]    m_state;
    int            m_idx;
    int            m_cnt;
    logic [PW-1:0] m_prev;
    bit            m_prev_valid;
    bit            m_phase, m_pv, m_cam_smp, m_cam_seen, m_gs, m_es;
    logic [1:0]    m_ec;
    logic [PW-1:0] m_stall;

    task automatic chk_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 2'd0; m_idx = 0; m_cnt = 0; m_prev = '0; m_prev_valid = 0;
        m_phase = 0; m_pv = 0; m_cam_smp = 0; m_cam_seen = 0;
        m_gs = 0; m_es = 0; m_ec = 2'd0; m_stall = '0;
    endtask

    task automatic drop_lock();
        m_pv = 0;
        m_cam_seen = 0;
    endtask

    // One clock of expected behaviour, from the inputs currently driven
    task automatic model_cycle();
        bit            gap;
        logic [1:0]    old_st;
        logic [PW-1:0] snx;
        old_st = m_state;
        gap = m_prev_valid && (longint'(tooth_period) >= 2 * longint'(m_prev));
        snx = (m_stall == {PW{1'b1}}) ? m_stall : m_stall + 1'b1;
        m_gs = 0;
        m_es = 0;
        if (!en) begin
            drop_lock();
            m_state = 2'd0;
        end else if (!tooth_stb && m_state != 2'd0 && snx >= stall_limit) begin
            drop_lock();
            m_state = 2'd0;
            m_es = 1;
            m_ec = 2'd3;
        end else if (tooth_stb) begin
            case (m_state)
                2'd0: m_state = 2'd1;
                2'd1: if (gap) begin m_state = 2'd2; m_cnt = 0; end
                2'd2: begin
                    if (gap && m_cnt == TN - 1) begin m_state = 2'd3; m_idx = 0; end
                    else if (gap) begin m_state = 2'd1; m_ec = 2'd1; end
                    else if (m_cnt == TN - 1) begin m_state = 2'd1; m_ec = 2'd2; end
                    else m_cnt++;
                end
                default: begin
                    if (gap && m_idx == TN - 1) begin
                        m_idx = 0;
                        m_gs = 1;
                        if (m_cam_seen) begin m_phase = m_cam_smp; m_pv = 1; end
                        else m_phase = !m_phase;
                        m_cam_seen = 0;
                    end else if (gap || m_idx == TN - 1) begin
                        m_es = 1;
                        m_ec = gap ? 2'd1 : 2'd2;
                        drop_lock();
                        m_state = 2'd1;
                    end else begin
                        m_idx++;
                        if (m_idx == CT) begin m_cam_smp = cam_lvl; m_cam_seen = 1; end
                    end
                end
            endcase
        end
        if (!en || (old_st == 2'd0 && !tooth_stb)) m_prev_valid = 0;
        else if (tooth_stb) m_prev_valid = 1;
        if (tooth_stb) m_prev = tooth_period;
        m_stall = tooth_stb ? '0 : snx;
    endtask

    // Drive one cycle, queue the model's expectation, compare after the edge
    task automatic tick(input bit stb, input logic [PW-1:0] per);
        exp_t e;
        tooth_stb = stb;
        tooth_period = per;
        model_cycle();
        e.st = m_state; e.idx = 6'(m_idx); e.ph = m_phase; e.pv = m_pv;
        e.gs = m_gs; e.es = m_es; e.ec = m_ec;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        tooth_stb = 1'b0;
        e = sb_q.pop_front();
        if (err_stb === 1'b1) es_seen++;
        chk_val("sync_state", 32'(sync_state), 32'(e.st));
        chk_val("angle_en", 32'(angle_en), 32'(e.st == 2'd3));
        chk_val("tooth_idx", 32'(tooth_idx), 32'(e.idx));
        chk_val("phase", 32'(phase), 32'(e.ph));
        chk_val("phase_valid", 32'(phase_valid), 32'(e.pv));
        chk_val("gap_stb", 32'(gap_stb), 32'(e.gs));
        chk_val("err_stb", 32'(err_stb), 32'(e.es));
        chk_val("err_code", 32'(err_code), 32'(e.ec));
        chk_val("stb_excl", 32'(gap_stb & err_stb), 32'd0);
    endtask

    task automatic idle();
        repeat ($urandom_range(0, 2)) tick(1'b0, tooth_period);
    endtask

    task automatic teeth(input int n, input logic [PW-1:0] per);
        for (int i = 0; i < n; i++) begin
            tick(1'b1, per);
            idle();
        end
    endtask

    // One revolution starting at the gap tooth; cam is high around tooth 30 on alternate turns
    task automatic full_rev(input logic [PW-1:0] per_n, input logic [PW-1:0] per_g, input bit ramp);
        logic [PW-1:0] p;
        for (int t = 0; t < TN; t++) begin
            cam_lvl = cam_rev && (t >= 26) && (t <= 34);
            if (t == 0) p = per_g;
            else if (ramp) p = PW'(64 - (16 * (t - 1)) / 56);
            else p = per_n;
            tick(1'b1, p);
            idle();
        end
        cam_lvl = 1'b0;
        cam_rev = !cam_rev;
    endtask

    // From STOP/SEEK to LOCK with tooth_idx at the last tooth
    task automatic sync_up();
        teeth(5, PW'(64));
        full_rev(PW'(64), PW'(192), 1'b0);
        full_rev(PW'(64), PW'(192), 1'b0);
        chk_val("sync_up_lock", 32'(sync_state), 32'd3);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk_val({tag, "_state"}, 32'(sync_state), 32'd0);
        chk_val({tag, "_angle_en"}, 32'(angle_en), 32'd0);
        chk_val({tag, "_idx"}, 32'(tooth_idx), 32'd0);
        chk_val({tag, "_phase"}, 32'(phase), 32'd0);
        chk_val({tag, "_pv"}, 32'(phase_valid), 32'd0);
        chk_val({tag, "_gap_stb"}, 32'(gap_stb), 32'd0);
        chk_val({tag, "_err_stb"}, 32'(err_stb), 32'd0);
        chk_val({tag, "_err_code"}, 32'(err_code), 32'd0);
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        rst = 1'b1;
        en  = 1'b1;

        // Nominal: two gaps to lock, then phase from the third gap
        teeth(10, PW'(64));
        chk_val("seek_after_teeth", 32'(sync_state), 32'd1);
        for (int r = 0; r < 5; r++) full_rev(PW'(64), PW'(192), 1'b0);
        chk_val("nominal_lock", 32'(sync_state), 32'd3);
        chk_val("nominal_pv", 32'(phase_valid), 32'd1);

        // Early gap at tooth 20
        tick(1'b1, PW'(192)); idle();
        teeth(20, PW'(64));
        chk_val("pre_early_idx", 32'(tooth_idx), 32'd20);
        tick(1'b1, PW'(192));
        chk_val("early_err_stb", 32'(err_stb), 32'd1);
        chk_val("early_code", 32'(err_code), 32'd1);
        chk_val("early_state", 32'(sync_state), 32'd1);
        chk_val("early_angle_en", 32'(angle_en), 32'd0);
        idle();

        // Missing gap at tooth 57
        sync_up();
        tick(1'b1, PW'(64));
        chk_val("miss_code", 32'(err_code), 32'd2);
        chk_val("miss_state", 32'(sync_state), 32'd1);
        idle();

        // Stall exactly stall_limit cycles after the last strobe
        sync_up();
        tick(1'b1, PW'(192)); idle();
        teeth(5, PW'(64));
        tick(1'b1, PW'(64));
        repeat (999) tick(1'b0, PW'(64));
        chk_val("stall_pre_state", 32'(sync_state), 32'd3);
        tick(1'b0, PW'(64));
        chk_val("stall_state", 32'(sync_state), 32'd0);
        chk_val("stall_err_stb", 32'(err_stb), 32'd1);
        chk_val("stall_code", 32'(err_code), 32'd3);
        tick(1'b0, PW'(64));
        chk_val("stall_err_single", 32'(err_stb), 32'd0);

        // Strobe on the threshold cycle keeps lock
        sync_up();
        tick(1'b1, PW'(192)); idle();
        teeth(3, PW'(64));
        tick(1'b1, PW'(64));
        repeat (999) tick(1'b0, PW'(64));
        tick(1'b1, PW'(64));
        chk_val("thr_state", 32'(sync_state), 32'd3);
        chk_val("thr_err_stb", 32'(err_stb), 32'd0);
        chk_val("thr_idx", 32'(tooth_idx), 32'd5);
        idle();

        // Acceleration: ramp 64 -> 48, then gap 144
        teeth(52, PW'(64));
        es_seen = 0;
        full_rev(PW'(64), PW'(192), 1'b1);
        full_rev(PW'(48), PW'(144), 1'b0);
        chk_val("accel_state", 32'(sync_state), 32'd3);
        chk_val("accel_no_err", 32'(es_seen), 32'd0);

        // en dropped at tooth 10
        tick(1'b1, PW'(144)); idle();
        teeth(10, PW'(48));
        chk_val("en_pre_idx", 32'(tooth_idx), 32'd10);
        en = 1'b0;
        tick(1'b0, PW'(48));
        chk_val("en_state", 32'(sync_state), 32'd0);
        chk_val("en_err_stb", 32'(err_stb), 32'd0);
        tick(1'b1, PW'(48));
        chk_val("en_hold_stop", 32'(sync_state), 32'd0);
        en = 1'b1;

        // Asynchronous reset mid-LOCK, then resync needs two gaps
        sync_up();
        tick(1'b1, PW'(192)); idle();
        teeth(10, PW'(64));
        #3;
        rst = 1'b0;
        #1;
        chk_reset_vals("async_rst");
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        teeth(5, PW'(64));
        full_rev(PW'(64), PW'(192), 1'b0);
        chk_val("rst_resync_verify", 32'(sync_state), 32'd2);
        tick(1'b1, PW'(192));
        chk_val("rst_resync_lock", 32'(sync_state), 32'd3);
        teeth(4, PW'(64));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_hwag_sync_ctrl
`default_nettype wire

// File: doc/hwag_sync_ctrl.md
# hwag_sync_ctrl

Crank/cam synchronisation controller for the hardware angle generator. It consumes the per-tooth capture strobe and tooth period produced by `hwag_core` from the VR input, locates the missing-tooth gap of the 60-2 wheel, and tracks the tooth index and the 720° cam phase. It gates angle generation (`angle_en`) only while the wheel pattern is verified, and reports loss of sync.

## Interface
- `TOOTH_NUM`, 58: real teeth per revolution; 57 normal strobes occur between gap strobes.
- `PERIOD_W`, 24: width of tooth period and stall counter.
- `CAM_TOOTH`, 30: tooth index at which `cam_lvl` is sampled.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `en`  in  1  sync enable; low forces STOP.
- `tooth_stb`  in  1  one-cycle pulse per captured tooth edge.
- `tooth_period`  in  PERIOD_W  clk count since the previous edge; valid with `tooth_stb`.
- `cam_lvl`  in  1  cam sensor level, already synchronised to `clk`.
- `stall_limit`  in  PERIOD_W  idle clk count that declares the engine stopped.
- `sync_state`  out  2  STOP=0, SEEK=1, VERIFY=2, LOCK=3.
- `angle_en`  out  1  high iff `sync_state`==LOCK.
- `tooth_idx`  out  $clog2(TOOTH_NUM)  tooth number; 0 = first tooth after the gap.
- `phase`  out  1  cam phase (0 = first 360°, 1 = second 360°).
- `phase_valid`  out  1  `phase` has been loaded from a cam sample.
- `gap_stb`  out  1  one-cycle pulse on an accepted gap tooth in LOCK.
- `err_stb`  out  1  one-cycle pulse on sync loss.
- `err_code`  out  2  NONE=0, EARLY_GAP=1, MISSING_GAP=2, STALL=3; holds until the next error.

## Operation
- Gap test: `gap = tooth_period >= 2*prev_period`, evaluated at PERIOD_W+1 bits with no overflow. `prev_period` loads on every `tooth_stb`. The test is invalid until one period has been stored after STOP (`prev_valid`).
- STOP:
  - Entered when `en`=0.
  - Entered when the stall counter reaches ≥ `stall_limit` while the state is not STOP; this also raises `err_stb` with `err_code`=STALL.
  - On `tooth_stb` with `en`=1: store the period and go to SEEK.
- SEEK:
  - Each `tooth_stb` with `prev_valid` and `gap`: go to VERIFY with `cnt`=0.
  - Otherwise: store the period and stay.
- VERIFY:
  - Non-gap strobe: `cnt`++.
  - Gap with `cnt`==TOOTH_NUM-1: go to LOCK with `tooth_idx`=0.
  - Gap with any other `cnt`: go to SEEK with `err_code`=EARLY_GAP.
  - Non-gap strobe with `cnt`==TOOTH_NUM-1: go to SEEK with `err_code`=MISSING_GAP.
  - No error in VERIFY pulses `err_stb`; `err_code` is updated only.
- LOCK:
  - Non-gap strobe with `tooth_idx`<TOOTH_NUM-1: `tooth_idx`++.
  - Gap strobe with `tooth_idx`==TOOTH_NUM-1: `tooth_idx`=0, pulse `gap_stb`, and update phase (see below).
  - Gap strobe with `tooth_idx`<TOOTH_NUM-1: `err_stb`, EARLY_GAP, go to SEEK.
  - Non-gap strobe with `tooth_idx`==TOOTH_NUM-1: `err_stb`, MISSING_GAP, go to SEEK.
- Phase handling:
  - In LOCK, a strobe landing on `tooth_idx`==CAM_TOOTH latches `cam_lvl` into `cam_smp` and sets `cam_seen`.
  - At the accepted gap: if `cam_seen`, then `phase`←`cam_smp` and `phase_valid`←1; else `phase` toggles. `cam_seen` then clears.
  - Leaving LOCK clears `phase_valid`.
- Stall counter:
  - Saturating; clears on `tooth_stb`, otherwise increments.
  - When `tooth_stb` and the threshold coincide, the tooth wins: no stall.
- `en` falling in any state: STOP next cycle, no `err_stb`, `err_code` unchanged.

## Timing
- Reset values:
  - `sync_state`=STOP, `tooth_idx`=0, `phase`=0, all flags, strobes and `err_code` = 0.
  - `prev_valid`=0, stall counter=0, `cnt`=0.
- All outputs are registered and update on the clock edge after the `tooth_stb` cycle (1-cycle latency). `angle_en` follows `sync_state` in the same cycle, because it is decoded from the state register.
- `gap_stb` and `err_stb` are high for exactly one cycle. They are never both high.
- Back-to-back `tooth_stb` on consecutive cycles must be handled; there is no dead cycle.
- Reset asserted mid-operation forces all reset values immediately (asynchronous). Release is synchronous to the next edge.

## Structure
- `hwag_pkg` holds:
  - `sync_state_t` (2-bit enum STOP/SEEK/VERIFY/LOCK)
  - `err_code_t` (2-bit enum)
  - the constants `GAP_RATIO_SHIFT`=1 and `TOOTH_NUM_DEF`=58
- Sub-module `hwag_gap_det` contains the `prev_period` register, `prev_valid`, and the gap comparison. It outputs a combinational `gap` qualified by `prev_valid`.
- The top level contains the FSM, the counters, the cam/phase logic, and the stall counter.

## Test plan
- Nominal 60-2 pattern:
  - Stimulus: period 64 clk for normal teeth, 192 clk at the gap, cam high on tooth 30 of alternate revolutions.
  - Response: STOP→SEEK→VERIFY→LOCK after the second gap; `tooth_idx` 0..57 repeats; `gap_stb` once per 58 strobes; `phase` alternates 0/1 with `phase_valid`=1 from the third gap.
- Early gap:
  - Stimulus: in LOCK, inject a 192-clk period at `tooth_idx`=20.
  - Response: `err_stb` pulse, `err_code`=1, `sync_state`=SEEK, `angle_en`=0.
- Missing gap:
  - Stimulus: replace the gap period with 64.
  - Response: `err_code`=2 at the strobe where `tooth_idx` was 57; state SEEK.
- Stall:
  - Stimulus: `stall_limit`=1000; stop strobes while in LOCK.
  - Response: exactly 1000 cycles after the last strobe, state STOP, `err_code`=3, single `err_stb`.
  - Also: a strobe on the threshold cycle gives no stall.
- Acceleration:
  - Stimulus: normal period ramps 64→48 over a revolution, gap 144.
  - Response: lock is retained and there is no `err_stb`.
- `en`/reset mid-LOCK:
  - Stimulus: drop `en` at `tooth_idx`=10.
  - Response: STOP next cycle with no `err_stb`.
  - Stimulus: assert `rst`=0 asynchronously between edges.
  - Response: all outputs go to reset values before the next edge; resync requires two gaps.
